pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Reads back a PWM waveform, such as the fan PWM pin or an external fan's PWM/tach-style square wave, and measures it.
- Reports high time and period in clock-enable ticks, with a one-tick valid strobe per complete period.
- Detects a stuck line (no edges) and reports it as 0 % or 100 % duty.
- It is the receive end of the PWM interface the fan controller drives. It is used for closed-loop self-check and for fan-speed feedback into the controller path.

Parameters:
- CNT_BITWIDTH, 6, width of the tick counter and measurement outputs. Saturation value CNT_MAX = 2^CNT_BITWIDTH-1 is also the stuck timeout.
- SYNC_STAGES, 2, number of input synchroniser flops (>= 2).

Ports:
- clk_i  in  1  system clock (1 MHz).
- rstn_i  in  1  reset. Asynchronous, active-low.
- clk_en_i  in  1  tick enable. All state, including the synchroniser, advances only when it is 1.
- pwm_i  in  1  asynchronous PWM input.
- high_cnt_o  out  CNT_BITWIDTH  measured high time in ticks.
- period_cnt_o  out  CNT_BITWIDTH  measured period in ticks.
- valid_o  out  1  one-clock pulse when the outputs update.
- stuck_o  out  1  1 while no edge has been seen for CNT_MAX ticks.
- level_o  out  1  synchronised input level.

Behaviour:
- Reset (async, rstn_i=0):
  - Synchroniser flops = 0, state = IDLE, cnt = 0, high_lat = 0.
  - All outputs = 0.
  - Reset mid-measurement discards the partial period; there is no valid pulse on exit.
- Edge detect: rise = sync & ~sync_d, fall = ~sync & sync_d, evaluated on enabled ticks only. The fixed synchroniser latency cancels out in the measurements.
- cnt increments by 1 per enabled tick and saturates at CNT_MAX. Saturation in any state except STUCK means a timeout.
- IDLE:
  - cnt counts.
  - When the synchronised level = 0, go to ARM. This guarantees the first high phase is complete.
- ARM:
  - cnt counts.
  - On rise: cnt <= 1, go to HIGH.
- HIGH:
  - On fall: high_lat <= cnt, cnt <= cnt+1, go to LOW.
- LOW:
  - On rise: high_cnt_o <= high_lat, period_cnt_o <= cnt, valid_o = 1 for that clock, cnt <= 1, go to HIGH.
- Timeout (cnt == CNT_MAX with no edge, in IDLE/ARM/HIGH/LOW):
  - Go to STUCK, stuck_o <= 1, valid_o pulses once.
  - Stuck at level 1: high_cnt_o = period_cnt_o = CNT_MAX (100 % duty).
  - Stuck at level 0: high_cnt_o = 0, period_cnt_o = CNT_MAX (0 % duty).
- STUCK:
  - On rise: stuck_o <= 0, cnt <= 1, go to HIGH.
  - On fall: stuck_o <= 0, go to ARM with cnt <= 0.
  - Outputs hold until the next valid.
- Measurement semantics: with clk_en_i=1 and an input of high H clocks / period P clocks (both < CNT_MAX), the block reports high_cnt_o = H and period_cnt_o = P.
  - The first valid arrives one full period after the first rising edge following a low.
- Simultaneous timeout and edge on the same tick: the edge wins, so there is no STUCK entry.
- Held outputs:
  - high_cnt_o, period_cnt_o and stuck_o change only together with valid_o, or on STUCK exit for stuck_o.
  - valid_o is never asserted on a tick with clk_en_i=0.
- Pulses shorter than 1 tick after synchronisation are not seen; no further glitch filter is applied.
- Implementation size: roughly 150-250 lines of RTL.

Decomposition:
- Shared package: state encoding (IDLE, ARM, HIGH, LOW, STUCK) and the CNT_MAX derivation helper. These are reused by FanCTRL-side feedback logic.
- One sub-module, pwm_capture_sync: SYNC_STAGES flop chain with clk_en_i gating. It outputs the synchronised level and the rise/fall pulses.

Test Plan:
- clk_en_i=1, PWM period 18 / high 7, driven from a FanCTRL-style PWM counter with reset released low:
  - first valid after the 2nd rising edge with high_cnt_o=7, period_cnt_o=18;
  - thereafter one valid every 18 clocks.
- clk_en_i toggling 1-of-2, PWM period 36 clocks / high 14 clocks -> high_cnt_o=7, period_cnt_o=18, valid_o only on enabled cycles.
- pwm_i held 1 after one valid period:
  - 63 ticks after the last edge: stuck_o=1, single valid, high_cnt_o=63, period_cnt_o=63;
  - PWM resumes -> stuck_o clears on the first rise and a normal measurement follows one period later.
- pwm_i held 0 from reset -> IDLE→ARM, timeout: stuck_o=1, high_cnt_o=0, period_cnt_o=63.
- rstn_i asserted mid-HIGH phase:
  - all outputs = 0 immediately (asynchronous);
  - after release with pwm_i high, no valid until a full low→high→low→high sequence.
- Duty 0→3→18 of period 18, a changing duty step -> reported high counts follow 0 (via stuck), 3, 18 (stuck high, 63/63).
  - Verify no spurious valid pulses and period_cnt_o stays 18 for non-stuck periods.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: capture FSM states and counter helper shared with fan-control feedback logic
package pwm_capture_pkg;
  typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, STUCK} state_t;
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: tick-gated input synchroniser with rise/fall pulses on enabled ticks
module pwm_capture_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clk_en_i,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic level_d;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else if (clk_en_i) begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = clk_en_i & level_o & ~level_d;
  assign fall_o  = clk_en_i & ~level_o & level_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in ticks, flags a stuck line as 0 % or 100 % duty
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_BITWIDTH = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic                    pwm_i,
  output logic [CNT_BITWIDTH-1:0] high_cnt_o,
  output logic [CNT_BITWIDTH-1:0] period_cnt_o,
  output logic                    valid_o,
  output logic                    stuck_o,
  output logic                    level_o
);
  localparam logic [CNT_BITWIDTH-1:0] CNT_MAX = CNT_BITWIDTH'(cnt_max(CNT_BITWIDTH));
  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);
  localparam logic [CNT_BITWIDTH-1:0] ARM_MIN = CNT_BITWIDTH'(SYNC_STAGES);
  state_t state;
  logic [CNT_BITWIDTH-1:0] cnt, cnt_inc, high_lat;
  logic level, rise, fall, timeout, valid_q;
  pwm_capture_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .pwm_i(pwm_i),
    .level_o(level), .rise_o(rise), .fall_o(fall)
  );
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign timeout = (cnt == CNT_MAX) && !rise && !fall && (state != STUCK);
  // the strobe waits for an enabled tick so it never shows while clk_en_i is low
  assign valid_o = valid_q & clk_en_i;
  assign level_o = level;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state        <= IDLE;
      cnt          <= '0;
      high_lat     <= '0;
      high_cnt_o   <= '0;
      period_cnt_o <= '0;
      valid_q      <= 1'b0;
      stuck_o      <= 1'b0;
    end else if (clk_en_i) begin
      valid_q <= 1'b0;
      if (timeout) begin
        state        <= STUCK;
        stuck_o      <= 1'b1;
        valid_q      <= 1'b1;
        high_cnt_o   <= level ? CNT_MAX : '0;
        period_cnt_o <= CNT_MAX;
      end else
        case (state)
          // the synchroniser holds reset zeros until it has filled, so low is trusted only after that
          IDLE: begin
            cnt <= cnt_inc;
            if (!level && cnt >= ARM_MIN) state <= ARM;
          end
          ARM:
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end else cnt <= cnt_inc;
          HIGH: begin
            cnt <= cnt_inc;
            if (fall) begin
              high_lat <= cnt;
              state    <= LOW;
            end
          end
          LOW:
            if (rise) begin
              high_cnt_o   <= high_lat;
              period_cnt_o <= cnt;
              valid_q      <= 1'b1;
              cnt          <= CNT_ONE;
              state        <= HIGH;
            end else cnt <= cnt_inc;
          STUCK:
            if (rise) begin
              stuck_o <= 1'b0;
              cnt     <= CNT_ONE;
              state   <= HIGH;
            end else if (fall) begin
              stuck_o <= 1'b0;
              cnt     <= '0;
              state   <= ARM;
            end else cnt <= cnt_inc;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table-driven, hand-sequenced and random PWM checks against a period-level scoreboard
module tb_pwm_capture;
  localparam int W = 6;
  localparam int MAX = 63;
  logic clk_i = 1'b0, rstn_i = 1'b1, clk_en_i = 1'b1, pwm_i = 1'b0;
  logic [W-1:0] high_cnt_o, period_cnt_o;
  logic valid_o, stuck_o, level_o;
  pwm_capture dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i), .pwm_i(pwm_i),
    .high_cnt_o(high_cnt_o), .period_cnt_o(period_cnt_o),
    .valid_o(valid_o), .stuck_o(stuck_o), .level_o(level_o)
  );
  always #500 clk_i = ~clk_i;

  typedef struct {int h; int p; bit s;} exp_t;
  typedef struct {int h; int l; int n; int mode; int eh; int ep;} vec_t;
  exp_t q[$];
  int checks = 0, errors = 0, en_mode = 0, vcount = 0;
  int ph = 0, pl = 0;
  bit have_prev = 1'b0;
  longint cyc = 0, vcyc_last = 0, vcyc_prev = 0;

  always @(posedge clk_i) cyc++;
  initial forever begin
    @(posedge clk_i);
    #1;
    clk_en_i = (en_mode == 0) ? 1'b1 : (en_mode == 1) ? ~clk_en_i : ($urandom % 4 != 0);
  end

  // every valid must match the oldest period the stimulus has completed
  always @(negedge clk_i)
    if (valid_o) begin
      exp_t e;
      checks++;
      vcount++;
      vcyc_prev = vcyc_last;
      vcyc_last = cyc;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got high=%0d period=%0d stuck=%0d, required no valid",
                 high_cnt_o, period_cnt_o, stuck_o);
      end else begin
        e = q.pop_front();
        if (high_cnt_o != e.h || period_cnt_o != e.p || stuck_o != e.s || !clk_en_i) begin
          errors++;
          $display("FAIL valid_data: got high=%0d period=%0d stuck=%0d en=%0d, required high=%0d period=%0d stuck=%0d en=1",
                   high_cnt_o, period_cnt_o, stuck_o, clk_en_i, e.h, e.p, e.s);
        end
      end
    end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk_i);
      if (clk_en_i) k++;
    end
    #1;
  endtask

  task automatic do_reset(input bit lvl);
    rstn_i = 1'b0;
    pwm_i = lvl;
    #1;
    check("reset_outputs", int'({high_cnt_o, period_cnt_o, valid_o, stuck_o, level_o}), 0);
    check("queue_drained", q.size(), 0);
    q.delete();
    have_prev = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic drive_rise();
    if (have_prev) q.push_back('{ph, ph + pl, 1'b0});
    have_prev = 1'b1;
    pwm_i = 1'b1;
  endtask

  task automatic pwm_cycle(input int h, input int l);
    drive_rise();
    wait_ticks(h);
    pwm_i = 1'b0;
    wait_ticks(l);
    ph = h;
    pl = l;
  endtask

  task automatic expect_timeout(input bit lvl);
    q.push_back('{lvl ? MAX : 0, MAX, 1'b1});
    have_prev = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int v0;
    tbl[0] = '{7, 11, 4, 0, 7, 18};
    tbl[1] = '{7, 11, 4, 1, 7, 18};
    tbl[2] = '{3, 15, 3, 0, 3, 18};
    tbl[3] = '{1, 17, 3, 0, 1, 18};
    tbl[4] = '{30, 30, 3, 0, 30, 60};
    tbl[5] = '{20, 42, 2, 0, 20, 62};
    tbl[6] = '{61, 1, 2, 2, 61, 62};
    tbl[7] = '{62, 1, 2, 0, 62, 63};
    for (int r = 0; r < 8; r++) begin
      en_mode = tbl[r].mode;
      do_reset(1'b0);
      wait_ticks(4);
      v0 = vcount;
      for (int j = 0; j < tbl[r].n; j++) begin
        if (j > 0) q.push_back('{tbl[r].eh, tbl[r].ep, 1'b0});
        pwm_i = 1'b1;
        wait_ticks(tbl[r].h);
        pwm_i = 1'b0;
        wait_ticks(tbl[r].l);
      end
      q.push_back('{tbl[r].eh, tbl[r].ep, 1'b0});
      pwm_i = 1'b1;
      wait_ticks(6);
      check($sformatf("row%0d_valid_count", r), vcount - v0, tbl[r].n);
      if (tbl[r].mode == 0) check($sformatf("row%0d_spacing", r), int'(vcyc_last - vcyc_prev), tbl[r].ep);
      pwm_i = 1'b0;
    end

    // stuck low from reset, recovery, duty 3 of 18, then stuck high and recovery
    en_mode = 0;
    do_reset(1'b0);
    expect_timeout(1'b0);
    wait_ticks(63);
    check("stuck0_before", stuck_o, 0);
    wait_ticks(1);
    check("stuck0_set", stuck_o, 1);
    check("stuck0_high", high_cnt_o, 0);
    check("stuck0_period", period_cnt_o, MAX);
    drive_rise();
    wait_ticks(2);
    check("stuck0_hold", stuck_o, 1);
    wait_ticks(1);
    check("stuck0_clear", stuck_o, 0);
    pwm_i = 1'b0;
    wait_ticks(15);
    ph = 3;
    pl = 15;
    pwm_cycle(3, 15);
    pwm_cycle(3, 15);
    drive_rise();
    expect_timeout(1'b1);
    wait_ticks(65);
    check("stuck1_before", stuck_o, 0);
    wait_ticks(1);
    check("stuck1_set", stuck_o, 1);
    check("stuck1_high", high_cnt_o, MAX);
    check("stuck1_period", period_cnt_o, MAX);
    pwm_i = 1'b0;
    wait_ticks(2);
    check("stuck1_hold", stuck_o, 1);
    wait_ticks(1);
    check("stuck1_clear", stuck_o, 0);
    wait_ticks(10);
    pwm_cycle(7, 11);
    pwm_cycle(7, 11);
    drive_rise();
    wait_ticks(6);
    check("resume_drained", q.size(), 0);

    // reset in the middle of a high phase, then restart with the line high
    pwm_i = 1'b0;
    do_reset(1'b0);
    wait_ticks(4);
    pwm_cycle(7, 11);
    drive_rise();
    wait_ticks(5);
    check("pre_reset_high", high_cnt_o, 7);
    #100;
    do_reset(1'b1);
    wait_ticks(5);
    pwm_i = 1'b0;
    wait_ticks(6);
    pwm_cycle(5, 13);
    drive_rise();
    wait_ticks(6);
    check("after_reset_drained", q.size(), 0);
    check("after_reset_period", period_cnt_o, 18);

    // random duty and period with random tick enable
    en_mode = 2;
    pwm_i = 1'b0;
    do_reset(1'b0);
    wait_ticks(4);
    for (int i = 0; i < 40; i++) pwm_cycle(1 + int'($urandom % 30), 1 + int'($urandom % 31));
    drive_rise();
    en_mode = 0;
    wait_ticks(8);
    check("random_drained", q.size(), 0);
    check("random_no_stuck", stuck_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
